// File: rtl/aes_key_pkg.sv
// aes_key_pkg: key-size codes, round counts and controller state encoding
package aes_key_pkg;
   localparam logic [1:0] KS_128 = 2'd0;
   localparam logic [1:0] KS_192 = 2'd1;
   localparam logic [1:0] KS_256 = 2'd2;
   localparam logic [1:0] KS_BAD = 2'd3;
   localparam logic [3:0] NR_128 = 4'd10;
   localparam logic [3:0] NR_192 = 4'd12;
   localparam logic [3:0] NR_256 = 4'd14;
   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_EXPAND, S_READY} state_t;
   function automatic logic [3:0] nr_of(input logic [1:0] key_size);
      return key_size == KS_128 ? NR_128 : key_size == KS_192 ? NR_192 : key_size == KS_256 ? NR_256 : 4'd0;
   endfunction
endpackage

// File: rtl/aes_rk_store.sv
// aes_rk_store: round-key register file, one write port, registered read port, sync zeroize
module aes_rk_store
   import aes_key_pkg::*;
#(
   parameter int NR_MAX = 14
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         zeroize,
   input  logic         wr_en,
   input  logic [3:0]   wr_idx,
   input  logic [127:0] wr_data,
   input  logic         rd_en,
   input  logic [3:0]   rd_idx,
   output logic [127:0] rd_data,
   output logic         rd_valid
);
   logic [127:0] mem [NR_MAX+1];
   // read samples the array before this edge's write lands
   always_ff @(posedge clk) begin
      if (reset || zeroize) mem <= '{default: '0};
      else if (wr_en) mem[wr_idx] <= wr_data;
      rd_valid <= !reset && rd_en;
      rd_data <= (!reset && rd_en) ? mem[rd_idx] : '0;
   end
endmodule

// File: rtl/aes_round_key_ctrl.sv
// aes_round_key_ctrl: sequences the key expander and serves the captured round keys
module aes_round_key_ctrl
   import aes_key_pkg::*;
#(
   parameter int NR_MAX      = 14,
   parameter int WDOG_CYCLES = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         key_load,
   input  logic [1:0]   key_size,
   input  logic [255:0] key_in,
   input  logic         cipher_active,
   output logic         key_busy,
   output logic         key_ready,
   output logic         key_load_err,
   output logic [3:0]   num_rounds,
   output logic         exp_start,
   output logic [1:0]   exp_sel,
   output logic [255:0] exp_key,
   input  logic [127:0] exp_subkey,
   input  logic         exp_valid,
   input  logic         rk_rd_en,
   input  logic [3:0]   rk_rd_idx,
   output logic [127:0] rk_rd_data,
   output logic         rk_rd_valid
);
   localparam int WW = $clog2(WDOG_CYCLES + 1);
   state_t state, state_nxt;
   logic [3:0] wr_idx;
   logic [WW-1:0] wdog;
   logic accept, beat, last, abort, rd_ok;
   always_comb begin
      accept = key_load && (state == S_IDLE || state == S_READY) && !cipher_active && key_size != KS_BAD;
      beat = state == S_EXPAND && exp_valid;
      last = beat && wr_idx == num_rounds;
      abort = state == S_EXPAND && !exp_valid && wdog == WW'(WDOG_CYCLES - 1);
      rd_ok = rk_rd_en && state == S_READY && rk_rd_idx <= num_rounds;
      state_nxt = accept ? S_LAUNCH : state == S_LAUNCH ? S_EXPAND : last ? S_READY : abort ? S_IDLE : state;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         wr_idx <= '0;
         wdog <= '0;
         key_load_err <= 1'b0;
         num_rounds <= '0;
         exp_sel <= '0;
         exp_key <= '0;
      end else begin
         state <= state_nxt;
         key_load_err <= (key_load && !accept) || abort;
         wdog <= (state == S_EXPAND && !exp_valid && !abort) ? wdog + 1'b1 : '0;
         wr_idx <= accept ? 4'd1 : beat ? wr_idx + 4'd1 : wr_idx;
         if (accept) begin
            exp_key <= key_in;
            exp_sel <= key_size;
            num_rounds <= nr_of(key_size);
         end
      end
   end
   assign exp_start = state == S_LAUNCH;
   assign key_busy = state == S_LAUNCH || state == S_EXPAND;
   assign key_ready = state == S_READY;
   // the load's top 128 bits are round key 0; later slots come from the expander
   aes_rk_store #(.NR_MAX(NR_MAX)) u_store (
      .clk      (clk),
      .reset    (reset),
      .zeroize  (abort),
      .wr_en    (accept || beat),
      .wr_idx   (accept ? 4'd0 : wr_idx),
      .wr_data  (accept ? key_in[255:128] : exp_subkey),
      .rd_en    (rd_ok),
      .rd_idx   (rk_rd_idx),
      .rd_data  (rk_rd_data),
      .rd_valid (rk_rd_valid)
   );
endmodule

// File: tb/tb_aes_round_key_ctrl.sv
// tb_aes_round_key_ctrl: directed bench with a transaction-level key-store model and FIPS-197 golden schedules
module tb_aes_round_key_ctrl;
   localparam int WDOG = 4;
   logic clk = 0, reset = 1, key_load = 0, cipher_active = 0, exp_valid = 0, rk_rd_en = 0;
   logic [1:0] key_size = 0;
   logic [255:0] key_in = 0;
   logic [127:0] exp_subkey = 0;
   logic [3:0] rk_rd_idx = 0;
   logic key_busy, key_ready, key_load_err, exp_start, rk_rd_valid;
   logic [3:0] num_rounds;
   logic [1:0] exp_sel;
   logic [255:0] exp_key;
   logic [127:0] rk_rd_data;
   int tests = 0, fails = 0, starts = 0;
   bit chk_en = 0;
   bit m_ready, m_busy, m_start, m_err, e_rdv;
   logic [3:0] m_nr, m_got;
   int m_idle;
   logic [255:0] m_key;
   logic [1:0] m_sel;
   logic [127:0] m_store [16];
   logic [127:0] e_rdd, keep;
   logic [7:0] sbox [256];
   logic [31:0] w [60];
   logic [127:0] gold [15];
   logic [255:0] k128, k192, k256;

   aes_round_key_ctrl dut (
      .clk(clk), .reset(reset), .key_load(key_load), .key_size(key_size), .key_in(key_in),
      .cipher_active(cipher_active), .key_busy(key_busy), .key_ready(key_ready),
      .key_load_err(key_load_err), .num_rounds(num_rounds), .exp_start(exp_start),
      .exp_sel(exp_sel), .exp_key(exp_key), .exp_subkey(exp_subkey), .exp_valid(exp_valid),
      .rk_rd_en(rk_rd_en), .rk_rd_idx(rk_rd_idx), .rk_rd_data(rk_rd_data), .rk_rd_valid(rk_rd_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] want);
      tests++;
      if (act !== want) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, want);
      end
   endtask

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 0; x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   task automatic build_sbox;
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 0;
         for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subw(input logic [31:0] t);
      return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
   endfunction

   // textbook word-wise key expansion, one 128-bit round key per four words
   task automatic expand(input logic [255:0] k, input int ks);
      int nk, nr;
      logic [31:0] t;
      logic [7:0] rc;
      nk = 4 + 2 * ks; nr = 10 + 2 * ks; rc = 8'h01;
      for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
      for (int i = nk; i < 4 * (nr + 1); i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = xt(rc);
         end else if (nk == 8 && i % nk == 4) t = subw(t);
         w[i] = w[i-nk] ^ t;
      end
      for (int r = 0; r < 15; r++) gold[r] = r <= nr ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
   endtask

   task automatic m_reset;
      m_ready = 0; m_busy = 0; m_start = 0; m_err = 0; m_nr = 0; m_got = 0; m_idle = 0;
      m_key = 0; m_sel = 0;
      for (int i = 0; i < 16; i++) m_store[i] = 0;
   endtask

   // what one clock edge must do to the store given the inputs present at that edge
   task automatic model_step;
      bit err;
      err = 0;
      if (key_load && !m_busy && !cipher_active && key_size != 2'd3) begin
         m_key = key_in; m_sel = key_size; m_nr = 4'(10 + 2 * key_size);
         m_store[0] = key_in[255:128];
         m_got = 0; m_idle = 0; m_ready = 0; m_busy = 1; m_start = 1;
      end else begin
         err = key_load;
         if (m_start) m_start = 0;
         else if (m_busy && exp_valid) begin
            m_got++;
            m_store[m_got] = exp_subkey;
            m_idle = 0;
            if (m_got == m_nr) begin m_busy = 0; m_ready = 1; end
         end else if (m_busy) begin
            m_idle++;
            if (m_idle == WDOG) begin
               m_busy = 0; m_idle = 0; err = 1;
               for (int i = 0; i < 16; i++) m_store[i] = 0;
            end
         end
      end
      m_err = err;
   endtask

   task automatic tick;
      logic v;
      logic [127:0] d;
      v = rk_rd_en && m_ready && (rk_rd_idx <= m_nr);
      d = v ? m_store[rk_rd_idx] : '0;
      @(posedge clk);
      if (reset) m_reset(); else model_step();
      e_rdv = reset ? 1'b0 : v;
      e_rdd = reset ? '0 : d;
      #1;
   endtask

   always @(negedge clk) if (chk_en) begin
      if (exp_start) starts++;
      chk("key_busy", 256'(key_busy), 256'(m_busy));
      chk("key_ready", 256'(key_ready), 256'(m_ready));
      chk("key_load_err", 256'(key_load_err), 256'(m_err));
      chk("exp_start", 256'(exp_start), 256'(m_start));
      chk("num_rounds", 256'(num_rounds), 256'(m_nr));
      chk("exp_sel", 256'(exp_sel), 256'(m_sel));
      chk("exp_key", exp_key, m_key);
      chk("rd_valid", 256'(rk_rd_valid), 256'(e_rdv));
      chk("rd_data", 256'(rk_rd_data), 256'(e_rdd));
   end

   task automatic load(input logic [255:0] k, input logic [1:0] ks);
      key_load = 1; key_in = k; key_size = ks;
      tick();
      key_load = 0;
   endtask

   task automatic rd(input logic [3:0] idx);
      rk_rd_en = 1; rk_rd_idx = idx;
      tick();
      rk_rd_en = 0;
   endtask

   task automatic run_exp(input int n, input int gap, input bit disturb);
      tick();
      repeat (gap) tick();
      for (int i = 1; i <= n; i++) begin
         exp_valid = 1; exp_subkey = gold[i];
         if (disturb && i == 3) cipher_active = 1;
         key_load = disturb && i == 5;
         key_size = 0;
         tick();
         key_load = 0;
         if (disturb && i == 5) chk("err_in_expand", 256'(key_load_err), 256'(1));
      end
      exp_valid = 0; cipher_active = 0;
   endtask

   initial begin
      build_sbox();
      m_reset();
      tick();
      chk_en = 1;
      tick();
      chk("rst_ready", 256'(key_ready), 0);
      chk("rst_busy", 256'(key_busy), 0);
      chk("rst_nr", 256'(num_rounds), 0);
      reset = 0;
      k192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
      k256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
      k128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
      // 192-bit schedule from IDLE
      expand(k192, 1);
      chk("gold192_rk1", 256'(gold[1]), 256'(128'h10111213141516175846f2f95c43f4fe));
      load(k192, 2'd1);
      chk("launch_start", 256'(exp_start), 1);
      run_exp(12, 2, 0);
      chk("start_once", 256'(starts), 1);
      chk("ready192", 256'(key_ready), 1);
      chk("nr192", 256'(num_rounds), 12);
      rd(0);
      chk("rk0_192", 256'(rk_rd_data), 256'(128'h000102030405060708090a0b0c0d0e0f));
      rd(1);
      chk("rk1_192", 256'(rk_rd_data), 256'(128'h10111213141516175846f2f95c43f4fe));
      rd(13);
      chk("rd13_valid", 256'(rk_rd_valid), 0);
      chk("rd13_data", 256'(rk_rd_data), 0);
      rd(12);
      chk("rd12_valid", 256'(rk_rd_valid), 1);
      chk("rd12_data", 256'(rk_rd_data), 256'(gold[12]));
      // load refused while cipher runs
      cipher_active = 1;
      load(k256, 2'd2);
      chk("err_active", 256'(key_load_err), 1);
      chk("ready_kept", 256'(key_ready), 1);
      cipher_active = 0;
      rd(12);
      chk("store_kept", 256'(rk_rd_data), 256'(gold[12]));
      // 256-bit schedule, disturbed by cipher_active and a load mid-expansion
      expand(k256, 2);
      load(k256, 2'd2);
      run_exp(14, 0, 1);
      chk("nr256", 256'(num_rounds), 14);
      chk("ready256", 256'(key_ready), 1);
      // 128-bit reload together with a read of the old schedule
      keep = gold[13];
      rk_rd_en = 1; rk_rd_idx = 13;
      load(k128, 2'd0);
      rk_rd_en = 0;
      chk("old_rd_valid", 256'(rk_rd_valid), 1);
      chk("old_rd_data", 256'(rk_rd_data), 256'(keep));
      chk("ready_drop", 256'(key_ready), 0);
      expand(k128, 0);
      chk("gold128_rk10", 256'(gold[10]), 256'(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
      run_exp(10, 1, 0);
      chk("nr128", 256'(num_rounds), 10);
      rd(11);
      chk("rd11_valid", 256'(rk_rd_valid), 0);
      rd(10);
      chk("rd10_data", 256'(rk_rd_data), 256'(gold[10]));
      // expander stalls after 5 beats
      load(k128, 2'd0);
      run_exp(5, 0, 0);
      repeat (WDOG - 1) tick();
      chk("no_abort_yet", 256'(key_load_err), 0);
      tick();
      chk("abort_err", 256'(key_load_err), 1);
      chk("abort_ready", 256'(key_ready), 0);
      chk("abort_busy", 256'(key_busy), 0);
      rd(0);
      chk("abort_rd_valid", 256'(rk_rd_valid), 0);
      chk("abort_rd_data", 256'(rk_rd_data), 0);
      // invalid key size in IDLE
      load(k128, 2'd3);
      chk("err_size3", 256'(key_load_err), 1);
      chk("size3_busy", 256'(key_busy), 0);
      // reset on beat 6 of a 256-bit expansion
      expand(k256, 2);
      load(k256, 2'd2);
      tick();
      for (int i = 1; i <= 5; i++) begin
         exp_valid = 1; exp_subkey = gold[i];
         tick();
      end
      exp_subkey = gold[6]; reset = 1;
      tick();
      reset = 0; exp_valid = 0;
      chk("rst_mid_busy", 256'(key_busy), 0);
      chk("rst_mid_nr", 256'(num_rounds), 0);
      chk("rst_mid_key", exp_key, 0);
      chk("rst_mid_sel", 256'(exp_sel), 0);
      expand(k128, 0);
      load(k128, 2'd0);
      run_exp(10, 0, 0);
      chk("post_rst_ready", 256'(key_ready), 1);
      rd(4);
      chk("post_rst_rk4", 256'(rk_rd_data), 256'(gold[4]));
      tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/aes_round_key_ctrl.md
Name: aes_round_key_ctrl

Overview:
Sequences the AES key-expansion datapath and presents its output as a round-key store for the cipher datapath. It accepts a key-load request for a 128-, 192- or 256-bit key and starts the matching expander. It captures every round key into a 15-entry store and then serves indexed single-cycle-latency reads to the round engine. It also enforces key-change rules: no rekey while the cipher is active, plus an error path for invalid sizes and a stalled expander.

Parameters:
NR_MAX, 14, highest round index; the store holds NR_MAX+1 entries of 128 bits.
WDOG_CYCLES, 4, consecutive idle exp_valid cycles in EXPAND before abort.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
key_load  in  1  one-cycle load request
key_size  in  2  0=128, 1=192, 2=256, 3=invalid
key_in  in  256  key, MSB-aligned; 128/192-bit keys occupy the top bits
cipher_active  in  1  high while the round engine uses the store
key_busy  out  1  expansion in progress
key_ready  out  1  store holds a complete, valid schedule
key_load_err  out  1  one-cycle pulse on a rejected load or an abort
num_rounds  out  4  Nr of the loaded key: 10, 12 or 14
exp_start  out  1  one-cycle start pulse to the expander
exp_sel  out  2  selects the expander variant, equal to the latched key_size
exp_key  out  256  latched key to the expander
exp_subkey  in  128  round key from the expander
exp_valid  in  1  exp_subkey is valid this cycle
rk_rd_en  in  1  read request
rk_rd_idx  in  4  round index to read
rk_rd_data  out  128  round key read data
rk_rd_valid  out  1  rk_rd_data is valid

Behaviour:
- Reset values: FSM=IDLE; all outputs 0; store zeroized; wr_idx=0; watchdog=0.
- FSM states: IDLE, LAUNCH, EXPAND, READY.
- Load acceptance:
  - Legal in IDLE or READY, only when cipher_active=0 and key_size!=3.
  - Otherwise (EXPAND, LAUNCH, cipher_active=1, or size 3) the load is ignored and key_load_err pulses the next cycle. State and store are unchanged.
- Accepted load, same edge:
  - Latch exp_key=key_in and exp_sel=key_size.
  - Set num_rounds = 10/12/14.
  - Write store[0]=key_in[255:128].
  - Set wr_idx=1 and key_ready=0.
  - Go to LAUNCH.
- LAUNCH: exp_start=1 for exactly one cycle, key_busy=1, then go to EXPAND.
- EXPAND:
  - Each exp_valid beat writes store[wr_idx]=exp_subkey and increments wr_idx.
  - The beat with wr_idx==num_rounds finishes the schedule: go to READY, key_busy=0, key_ready=1 the next cycle.
  - Any exp_valid beats after completion are ignored.
- Watchdog:
  - Counts consecutive EXPAND cycles with exp_valid=0 and clears on every beat.
  - Reaching WDOG_CYCLES aborts: go to IDLE, pulse key_load_err, key_ready=0, key_busy=0, zeroize store.
- Expander contract: round keys rk1..rkNr arrive as consecutive valid beats in order, starting at most WDOG_CYCLES cycles after exp_start.
- Reads:
  - Registered, latency 1.
  - If rk_rd_en=1, state=READY and rk_rd_idx<=num_rounds, the next cycle gives rk_rd_valid=1 and rk_rd_data=store[idx].
  - Otherwise the next cycle gives rk_rd_valid=0 and rk_rd_data=0.
  - Reads in other states are not errors; they return valid=0.
- Simultaneous load and read in READY: the read completes against the old schedule (read samples before the write). key_ready drops the following cycle.
- cipher_active rising during EXPAND has no effect; key_ready stays 0 until completion.
- reset mid-EXPAND: returns to the reset state immediately. The expander is reset by the same reset.

Decomposition:
- Package aes_key_pkg:
  - key-size codes KS_128=0, KS_192=1, KS_256=2;
  - Nr constants 10/12/14;
  - FSM state enum;
  - function nr_of(key_size).
- Sub-module aes_rk_store:
  - (NR_MAX+1) x 128 register file, one write port, one registered read port;
  - synchronous zeroize input.
- FSM, watchdog and load checks live in the top module.

Test Plan:
- 192-bit key 000102…1617 loaded in IDLE; behavioural expander emits 12 beats → exp_start pulses once; key_ready after beat 12; num_rounds=12; store[0]=000102030405060708090a0b0c0d0e0f; store[1]=10111213141516175846f2f95c43f4fe.
- Read idx 13 after the 192-bit schedule → rk_rd_valid=0, data 0; read idx 12 → valid=1 and equal to the golden model.
- key_load while cipher_active=1 in READY → key_load_err pulse, key_ready stays 1, store unchanged; same with key_size=3 in IDLE.
- Expander stops after 5 beats of a 128-bit expansion → abort after 4 idle cycles: key_load_err, state IDLE, store reads 0, key_ready=0.
- 256-bit then 128-bit back-to-back loads in READY → num_rounds 14 then 10; index 11 is unreadable after the second load.
- reset asserted on beat 6 of a 256-bit expansion → all outputs 0 the next cycle; a new load then completes normally.
